// File: rtl/pad_power_seq.sv
// pad_power_seq: pad-ring power sequencer with per-pad drive/slew/Schmitt
// configuration registers behind a simple request/grant register port.
// Sequencing: OFF -> UP_PWR -> UP_IO -> UP_BIAS -> ON, with optional IO
// retention (RET) and a timed power-down through DN_BIAS -> DN_IO -> OFF.
// Each timed state dwells STEP_CYCLES cycles.
// Optional feature macro: PAD_SEQ_RET_EN enables the RET state and retc_o;
// without it ret_req_i is ignored and retc_o is tied low.
module pad_power_seq #(
    parameter int NUM_PADS    = 16,
    parameter int STEP_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pwr_en_i,
    input  logic                  ret_req_i,
    output logic                  pwrok_o,
    output logic                  iopwrok_o,
    output logic                  bias_o,
    output logic                  retc_o,
    output logic                  ready_o,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [4:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic                  cfg_gnt_o,
    output logic                  cfg_rvalid_o,
    output logic [31:0]           cfg_rdata_o,
    output logic [2*NUM_PADS-1:0] pad_drv_o,
    output logic [NUM_PADS-1:0]   pad_slw_o,
    output logic [NUM_PADS-1:0]   pad_smt_o
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_UP_PWR  = 3'd1,
        S_UP_IO   = 3'd2,
        S_UP_BIAS = 3'd3,
        S_ON      = 3'd4,
        S_RET     = 3'd5,
        S_DN_BIAS = 3'd6,
        S_DN_IO   = 3'd7
    } state_t;

`ifdef PAD_SEQ_RET_EN
    localparam logic RET_EN = 1'b1;
`else
    localparam logic RET_EN = 1'b0;
`endif

    localparam logic [7:0] CNT_LOAD   = 8'(STEP_CYCLES - 1);
    localparam logic [4:0] STATUS_ADR = 5'd31;

    // Control word per state, ordered {pwrok, iopwrok, bias, retc, ready}.
    function automatic logic [4:0] ctrl_of(state_t s);
        case (s)
            S_UP_PWR:  return 5'b10000;
            S_UP_IO:   return 5'b11000;
            S_UP_BIAS: return 5'b11100;
            S_ON:      return 5'b11101;
            S_RET:     return 5'b11110;
            S_DN_BIAS: return 5'b11000;
            S_DN_IO:   return 5'b10000;
            default:   return 5'b00000;
        endcase
    endfunction

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [4:0]            ctrl_q;
    logic [2*NUM_PADS-1:0] drv_q;
    logic [NUM_PADS-1:0]   slw_q;
    logic [NUM_PADS-1:0]   smt_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_data;
    logic                  cnt_zero;
    logic                  unused_wdata;

    assign cnt_zero = (cnt_q == 8'd0);

    // Sequencer: state, dwell counter and the registered control word move together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OFF;
            cnt_q   <= 8'd0;
            ctrl_q  <= 5'b00000;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all registers
            // sample the same pre-edge values, regardless of statement order.
            case (state_q)
                S_OFF: begin
                    if (pwr_en_i) begin
                        state_q <= S_UP_PWR; ctrl_q <= ctrl_of(S_UP_PWR); cnt_q <= CNT_LOAD;
                    end
                end
                S_UP_PWR: begin
                    if (!pwr_en_i) begin
                        state_q <= S_OFF; ctrl_q <= ctrl_of(S_OFF); cnt_q <= 8'd0;
                    end else if (cnt_zero) begin
                        state_q <= S_UP_IO; ctrl_q <= ctrl_of(S_UP_IO); cnt_q <= CNT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_UP_IO: begin
                    if (!pwr_en_i) begin
                        state_q <= S_DN_IO; ctrl_q <= ctrl_of(S_DN_IO); cnt_q <= CNT_LOAD;
                    end else if (cnt_zero) begin
                        state_q <= S_UP_BIAS; ctrl_q <= ctrl_of(S_UP_BIAS); cnt_q <= CNT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_UP_BIAS: begin
                    if (!pwr_en_i) begin
                        state_q <= S_DN_BIAS; ctrl_q <= ctrl_of(S_DN_BIAS); cnt_q <= CNT_LOAD;
                    end else if (cnt_zero) begin
                        state_q <= S_ON; ctrl_q <= ctrl_of(S_ON); cnt_q <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ON: begin
                    // Power-down wins over a simultaneous retention request.
                    if (!pwr_en_i) begin
                        state_q <= S_DN_BIAS; ctrl_q <= ctrl_of(S_DN_BIAS); cnt_q <= CNT_LOAD;
                    end else if (RET_EN && ret_req_i) begin
                        state_q <= S_RET; ctrl_q <= ctrl_of(S_RET); cnt_q <= 8'd0;
                    end
                end
                S_RET: begin
                    if (!pwr_en_i) begin
                        state_q <= S_DN_BIAS; ctrl_q <= ctrl_of(S_DN_BIAS); cnt_q <= CNT_LOAD;
                    end else if (!ret_req_i) begin
                        state_q <= S_ON; ctrl_q <= ctrl_of(S_ON); cnt_q <= 8'd0;
                    end
                end
                S_DN_BIAS: begin
                    // pwr_en_i is deliberately not looked at while powering down.
                    if (cnt_zero) begin
                        state_q <= S_DN_IO; ctrl_q <= ctrl_of(S_DN_IO); cnt_q <= CNT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_DN_IO: begin
                    if (cnt_zero) begin
                        state_q <= S_OFF; ctrl_q <= ctrl_of(S_OFF); cnt_q <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_OFF; ctrl_q <= ctrl_of(S_OFF); cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign pwrok_o   = ctrl_q[4];
    assign iopwrok_o = ctrl_q[3];
    assign bias_o    = ctrl_q[2];
    assign retc_o    = ctrl_q[1] & RET_EN;
    assign ready_o   = ctrl_q[0];

    // Read mux for the register port: pad fields, status word, or zero.
    always_comb begin
        // NOTE: default first so no path leaves rd_data unassigned (no latch).
        rd_data = 32'd0;
        if (cfg_addr_i == STATUS_ADR) begin
            rd_data = {16'd0, cnt_q, 4'd0, ready_o, state_q};
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (cfg_addr_i == 5'(i)) begin
                    rd_data = {28'd0, smt_q[i], slw_q[i], drv_q[2*i +: 2]};
                end
            end
        end
    end

    // Register port: pad config writes and the one-cycle read response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the pad config storage is only a few flops per pad and the
            // pads must come up in a known state, so it is reset like any register.
            drv_q    <= '0;
            slw_q    <= '0;
            smt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= cfg_req_i;
            rdata_q  <= (cfg_req_i && !cfg_we_i) ? rd_data : 32'd0;
            for (int i = 0; i < NUM_PADS; i++) begin
                if (cfg_req_i && cfg_we_i && cfg_addr_i == 5'(i)) begin
                    drv_q[2*i +: 2] <= cfg_wdata_i[1:0];
                    slw_q[i]        <= cfg_wdata_i[2];
                    smt_q[i]        <= cfg_wdata_i[3];
                end
            end
        end
    end

    assign unused_wdata = ^cfg_wdata_i[31:4];

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign pad_drv_o    = drv_q;
    assign pad_slw_o    = slw_q;
    assign pad_smt_o    = smt_q;

endmodule
